// File: rtl/img_rsz_blk_gather_pkg.sv
// Shared types and sizing for the image-resize block gatherer.
// The accumulator width is derived so a full-size block of maximum pixel values cannot overflow.
package ImgRszPkg;

   localparam int PXL_PRIM_COLOR_NUM  = 1;
   localparam int PXL_COLOR_W         = 8;
   localparam int RSZ_IMG_WIDTH_SIZE  = 2;
   localparam int RSZ_IMG_HEIGHT_SIZE = 2;
   localparam int BLK_WIDTH_MAX_SZ_W  = 3;
   localparam int BLK_HEIGHT_MAX_SZ_W = 3;
   localparam int BLK_MAX_SZ          = ((1 << BLK_WIDTH_MAX_SZ_W) - 1) *
                                        ((1 << BLK_HEIGHT_MAX_SZ_W) - 1);
   localparam int BLK_VAL_W           = PXL_COLOR_W + $clog2(BLK_MAX_SZ + 1);
   localparam int COL_IDX_W = (RSZ_IMG_WIDTH_SIZE  > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE)  : 1;
   localparam int ROW_IDX_W = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1;

   typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_COLOR_W-1:0] PxlData_t;
   typedef logic [PXL_PRIM_COLOR_NUM-1:0][BLK_VAL_W-1:0]   FcBlkVal_t;

   typedef enum logic [1:0] {
      GTH_IDLE,
      GTH_GATHER,
      GTH_DRAIN
   } GthState_e;

   function automatic FcBlkVal_t fc_add(input FcBlkVal_t acc, input PxlData_t pxl);
      FcBlkVal_t sum;
      for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
         sum[c] = acc[c] + BLK_VAL_W'(pxl[c]);
      end
      return sum;
   endfunction

endpackage

// File: rtl/img_rsz_blk_gather_if.sv
// Pixel-in / block-out bundle of the gatherer; slave is the gatherer side, master the environment.
interface img_rsz_blk_gather_if;
   import ImgRszPkg::*;

   PxlData_t                          PxlData;
   logic                              PxlVld;
   logic                              PxlRdy;
   logic [BLK_WIDTH_MAX_SZ_W-1:0]     BlkSzHor;
   logic [BLK_HEIGHT_MAX_SZ_W-1:0]    BlkSzVer;
   FcBlkVal_t                         CompBlkData;
   logic [RSZ_IMG_WIDTH_SIZE-1:0]     CompBlkXMsk;
   logic [RSZ_IMG_HEIGHT_SIZE-1:0]    CompBlkYMsk;
   logic                              CompBlkVld;
   logic                              CompBlkRdy;
   logic                              GthImgDone;
   logic                              GthErr;

   modport slave (
      input  PxlData, PxlVld, BlkSzHor, BlkSzVer, CompBlkRdy,
      output PxlRdy, CompBlkData, CompBlkXMsk, CompBlkYMsk, CompBlkVld, GthImgDone, GthErr
   );

   modport master (
      output PxlData, PxlVld, BlkSzHor, BlkSzVer, CompBlkRdy,
      input  PxlRdy, CompBlkData, CompBlkXMsk, CompBlkYMsk, CompBlkVld, GthImgDone, GthErr
   );

endinterface

// File: rtl/img_rsz_blk_gather_pos_cnt.sv
// Raster position tracker: in-block offsets, output column/row, and block/image end flags.
module img_rsz_blk_pos_cnt
   import ImgRszPkg::*;
(
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           adv_i,
   input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  hor_sz_i,
   input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] ver_sz_i,
   output logic [COL_IDX_W-1:0]           col_idx_o,
   output logic [ROW_IDX_W-1:0]           row_idx_o,
   output logic                           blk_end_o,
   output logic                           img_end_o
);

   logic [BLK_WIDTH_MAX_SZ_W-1:0]  hor_cnt_q, hor_cnt_d;
   logic [BLK_HEIGHT_MAX_SZ_W-1:0] ver_cnt_q, ver_cnt_d;
   logic [COL_IDX_W-1:0]           col_idx_q, col_idx_d;
   logic [ROW_IDX_W-1:0]           row_idx_q, row_idx_d;
   logic                           hor_last, ver_last, col_last, row_last;

   assign hor_last = (hor_cnt_q == hor_sz_i - BLK_WIDTH_MAX_SZ_W'(1));
   assign ver_last = (ver_cnt_q == ver_sz_i - BLK_HEIGHT_MAX_SZ_W'(1));
   assign col_last = (col_idx_q == COL_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1));
   assign row_last = (row_idx_q == ROW_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1));

   assign blk_end_o = hor_last && ver_last;
   assign img_end_o = blk_end_o && col_last && row_last;
   assign col_idx_o = col_idx_q;
   assign row_idx_o = row_idx_q;

   // Carry chain: HorCnt -> ColIdx -> VerCnt -> RowIdx, each wrapping to 0.
   always_comb begin
      hor_cnt_d = hor_cnt_q;
      ver_cnt_d = ver_cnt_q;
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      if (adv_i) begin
         if (!hor_last) begin
            hor_cnt_d = hor_cnt_q + BLK_WIDTH_MAX_SZ_W'(1);
         end else begin
            hor_cnt_d = '0;
            if (!col_last) begin
               col_idx_d = col_idx_q + COL_IDX_W'(1);
            end else begin
               col_idx_d = '0;
               if (!ver_last) begin
                  ver_cnt_d = ver_cnt_q + BLK_HEIGHT_MAX_SZ_W'(1);
               end else begin
                  ver_cnt_d = '0;
                  row_idx_d = row_last ? '0 : row_idx_q + ROW_IDX_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hor_cnt_q <= '0;
         ver_cnt_q <= '0;
         col_idx_q <= '0;
         row_idx_q <= '0;
      end else begin
         hor_cnt_q <= hor_cnt_d;
         ver_cnt_q <= ver_cnt_d;
         col_idx_q <= col_idx_d;
         row_idx_q <= row_idx_d;
      end
   end

endmodule

// File: rtl/img_rsz_blk_gather.sv
// Gathers raster pixels into per-column block sums and hands each finished block to the compute engine.
// Optional zero-size configuration check: define IMG_RSZ_GTH_ERR_CHK_EN.
module img_rsz_blk_gather
   import ImgRszPkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   img_rsz_blk_gather_if.slave  Gth
);

   GthState_e                      state_q;
   logic [BLK_WIDTH_MAX_SZ_W-1:0]  hor_sz_q, hor_sz_eff;
   logic [BLK_HEIGHT_MAX_SZ_W-1:0] ver_sz_q, ver_sz_eff;
   FcBlkVal_t                      acc_q [RSZ_IMG_WIDTH_SIZE];
   FcBlkVal_t                      blk_data_q;
   logic [RSZ_IMG_WIDTH_SIZE-1:0]  blk_xmsk_q;
   logic [RSZ_IMG_HEIGHT_SIZE-1:0] blk_ymsk_q;
   logic                           blk_vld_q;
   logic                           pxl_rdy, cap, cap_ok, cfg_bad, blk_hs;
   logic [COL_IDX_W-1:0]           col_idx;
   logic [ROW_IDX_W-1:0]           row_idx;
   logic                           blk_end, img_end;

   // The first capture of an image sees the live sizes; later ones use the latched copy.
   assign hor_sz_eff = (state_q == GTH_IDLE) ? Gth.BlkSzHor : hor_sz_q;
   assign ver_sz_eff = (state_q == GTH_IDLE) ? Gth.BlkSzVer : ver_sz_q;

   assign pxl_rdy = (state_q != GTH_DRAIN) && (!blk_vld_q || Gth.CompBlkRdy);
   assign cap     = Gth.PxlVld && pxl_rdy;
   assign blk_hs  = blk_vld_q && Gth.CompBlkRdy;
   assign cap_ok  = cap && !cfg_bad;

`ifdef IMG_RSZ_GTH_ERR_CHK_EN
   logic err_q;

   assign cfg_bad = (state_q == GTH_IDLE) && ((hor_sz_eff == '0) || (ver_sz_eff == '0));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         err_q <= 1'b0;
      end else if (cap && cfg_bad) begin
         err_q <= 1'b1;
      end
   end

   assign Gth.GthErr = err_q;
`else
   assign cfg_bad    = 1'b0;
   assign Gth.GthErr = 1'b0;
`endif

   img_rsz_blk_pos_cnt u_pos_cnt (
      .Clk       (Clk),
      .Reset     (Reset),
      .adv_i     (cap_ok),
      .hor_sz_i  (hor_sz_eff),
      .ver_sz_i  (ver_sz_eff),
      .col_idx_o (col_idx),
      .row_idx_o (row_idx),
      .blk_end_o (blk_end),
      .img_end_o (img_end)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= GTH_IDLE;
         hor_sz_q <= '0;
         ver_sz_q <= '0;
      end else begin
         case (state_q)
            GTH_IDLE: begin
               if (cap_ok) begin
                  hor_sz_q <= Gth.BlkSzHor;
                  ver_sz_q <= Gth.BlkSzVer;
                  state_q  <= img_end ? GTH_DRAIN : GTH_GATHER;
               end
            end
            GTH_GATHER: begin
               if (cap_ok && img_end) begin
                  state_q <= GTH_DRAIN;
               end
            end
            GTH_DRAIN: begin
               if (blk_hs) begin
                  state_q <= GTH_IDLE;
               end
            end
            default: state_q <= GTH_IDLE;
         endcase
      end
   end

   // A finishing capture both emits Acc+pixel and restarts that column's sum.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         blk_vld_q  <= 1'b0;
         blk_data_q <= '0;
         blk_xmsk_q <= '0;
         blk_ymsk_q <= '0;
         for (int i = 0; i < RSZ_IMG_WIDTH_SIZE; i++) begin
            acc_q[i] <= '0;
         end
      end else if (cap_ok) begin
         if (blk_end) begin
            blk_vld_q      <= 1'b1;
            blk_data_q     <= fc_add(acc_q[col_idx], Gth.PxlData);
            blk_xmsk_q     <= RSZ_IMG_WIDTH_SIZE'(1) << col_idx;
            blk_ymsk_q     <= RSZ_IMG_HEIGHT_SIZE'(1) << row_idx;
            acc_q[col_idx] <= '0;
         end else begin
            acc_q[col_idx] <= fc_add(acc_q[col_idx], Gth.PxlData);
            if (blk_hs) begin
               blk_vld_q <= 1'b0;
            end
         end
      end else if (blk_hs) begin
         blk_vld_q <= 1'b0;
      end
   end

   assign Gth.PxlRdy      = pxl_rdy;
   assign Gth.CompBlkData = blk_data_q;
   assign Gth.CompBlkXMsk = blk_xmsk_q;
   assign Gth.CompBlkYMsk = blk_ymsk_q;
   assign Gth.CompBlkVld  = blk_vld_q;
   assign Gth.GthImgDone  = (state_q == GTH_DRAIN) && blk_hs && !Reset;

endmodule

// File: doc/img_rsz_blk_gather.md
IMG_RSZ_BLK_GATHER -- requirements
Module: img_rsz_blk_gather

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: Clk (input, 1, rising-edge clock), then Reset (input, 1, synchronous active-high reset).
REQ-002 SHALL have PxlData input, PxlData_t: captured pixel, PXL_PRIM_COLOR_NUM colour fields.
REQ-003 SHALL have PxlVld input, 1: pixel valid; pixels arrive in raster order.
REQ-004 SHALL have PxlRdy output, 1: pixel accepted; capture = PxlVld & PxlRdy.
REQ-005 SHALL have BlkSzHor input, BLK_WIDTH_MAX_SZ_W: source pixels per block horizontally.
REQ-006 SHALL have BlkSzVer input, BLK_HEIGHT_MAX_SZ_W: source rows per block vertically.
REQ-007 SHALL have CompBlkData output, FcBlkVal_t: per-colour block sum.
REQ-008 SHALL have CompBlkXMsk output, RSZ_IMG_WIDTH_SIZE: one-hot output column of the block.
REQ-009 SHALL have CompBlkYMsk output, RSZ_IMG_HEIGHT_SIZE: one-hot output row of the block.
REQ-010 SHALL have CompBlkVld output, 1, and CompBlkRdy input, 1: block valid/ready handshake toward the compute engine.
REQ-011 SHALL have GthImgDone output, 1: single-cycle pulse when the final block of an image is handed off.
REQ-012 SHALL have GthErr output, 1: sticky configuration error flag (present only per REQ-027).

Function
REQ-013 SHALL run FSM IDLE -> GATHER -> DRAIN -> IDLE; IDLE->GATHER on first capture; GATHER->DRAIN on capture of the last pixel of the image; DRAIN->IDLE on handshake of the last block.
REQ-014 SHALL latch BlkSzHor/BlkSzVer on the first capture in IDLE; input changes are ignored until the FSM returns to IDLE.
REQ-015 SHALL track HorCnt (0..BlkSzHor-1), ColIdx (0..RSZ_IMG_WIDTH_SIZE-1), VerCnt (0..BlkSzVer-1), RowIdx (0..RSZ_IMG_HEIGHT_SIZE-1), advancing only on capture, each wrapping to 0 and carrying into the next.
REQ-016 SHALL keep one accumulator per output column, RSZ_IMG_WIDTH_SIZE entries of FcBlkVal_t; each capture adds the pixel colour-wise into Acc[ColIdx].
REQ-017 SHALL, when a capture has HorCnt=BlkSzHor-1 and VerCnt=BlkSzVer-1, load CompBlkData = Acc[ColIdx]+pixel, XMsk = 1<<ColIdx, YMsk = 1<<RowIdx and CompBlkVld=1 on the next cycle, and clear Acc[ColIdx] to 0 in the same cycle.
REQ-018 SHALL size accumulators so that BLK_MAX_SZ x max pixel value never overflows; no saturation or wrap is permitted.
REQ-019 SHALL hold CompBlkVld and all payload stable until CompBlkRdy=1; the handshake completes on the cycle with Vld&Rdy.
REQ-020 SHALL drive PxlRdy = ~CompBlkVld | CompBlkRdy, so back-to-back completions lose no block and take no bubble when Rdy=1.
REQ-021 SHALL drive PxlRdy=0 in DRAIN; pixels of the next image are accepted only from IDLE.
REQ-022 SHALL pulse GthImgDone for exactly one cycle, on the cycle the DRAIN handshake completes.
REQ-023 SHALL, with BlkSzHor=1 and BlkSzVer=1, emit every pixel as its own block (CompBlkData = pixel, zero-extended).

Reset
REQ-024 SHALL, on Reset, set FSM=IDLE, all counters and accumulators=0, CompBlkVld=0, GthImgDone=0, GthErr=0, CompBlkData/XMsk/YMsk=0; PxlRdy=1 in the following cycle.
REQ-025 SHALL, on Reset asserted mid-image, discard any partial sums and pending block, with no GthImgDone pulse.

Configuration
REQ-026 SHALL use macro IMG_RSZ_GTH_ERR_CHK_EN.
REQ-027 SHALL, with the macro defined, set GthErr when BlkSzHor=0 or BlkSzVer=0 at first capture, hold the FSM in IDLE and drop the pixel; GthErr clears only on Reset. Without the macro, GthErr SHALL be tied to 0, no check logic is present, and zero sizes are undefined.

Structure
REQ-028 SHALL take PxlData_t, FcBlkVal_t, PXL_PRIM_COLOR_NUM, RSZ_IMG_WIDTH_SIZE, RSZ_IMG_HEIGHT_SIZE, BLK_*_W and BLK_MAX_SZ from ImgRszPkg; the FSM state enum SHALL be added to ImgRszPkg.
REQ-029 SHALL instantiate one sub-module, img_rsz_blk_pos_cnt, holding the four position counters and the block/image-end flags.

Verification (RSZ_IMG_WIDTH_SIZE=2, RSZ_IMG_HEIGHT_SIZE=2, one colour)
REQ-030 SHALL cover: 2x2 blocks, 4x4 image of pixels 1..16, Rdy=1 -> blocks 14 (X=01,Y=01), 22 (X=10,Y=01), 46 (X=01,Y=10), 54 (X=10,Y=10), each 1 cycle after its last pixel; GthImgDone once.
REQ-031 SHALL cover: same stimulus, CompBlkRdy=0 for 5 cycles at first block -> payload 14 held, PxlRdy=0 for the next 5 cycles, no block lost.
REQ-032 SHALL cover: 1x1 blocks, 2x2 image of pixels 7,8,9,10 -> four blocks equal to the pixel values, one-hot masks in raster order.
REQ-033 SHALL cover: Reset after 6 pixels of REQ-030 stimulus, then the full image -> exactly the four REQ-030 blocks, with no stale sums.
REQ-034 SHALL cover: with IMG_RSZ_GTH_ERR_CHK_EN defined, BlkSzHor=0 at first pixel -> GthErr=1, CompBlkVld stays 0, FSM stays IDLE.
